ps2_key_fifo: RTL and testbench

- Upstream keyboard front end for the MiniAlu KEY instruction.
- Oversamples PS2_CLK/PS2_DATA on the system clock, deframes 11-bit PS/2 frames and checks parity, stop bit and timeout.
- Filters break (F0) and extended (E0) prefix codes and queues make scancodes in a small FIFO.
- The ALU reads the queue head as the KEY operand and pops one entry per executed KEY.

---
 rtl/ps2_key_fifo_if.sv | 26 ++
 rtl/ps2_key_fifo.sv | 171 +++++++++++++++++
 tb/tb_ps2_key_fifo.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_fifo_if.sv
// Port bundle for the PS/2 key queue: raw keyboard pins in, ALU-facing key queue out.
// The slave modport is the queue itself; the master modport is whoever drives the pins and pops.
interface ps2_key_fifo_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          PS2_CLK;
    logic          PS2_DATA;
    logic          iPop;
    logic [7:0]    oKey;
    logic          oKeyValid;
    logic [CW-1:0] oCount;
    logic          oFrameErr;
    logic          oOverflow;

    modport slave (
        input  PS2_CLK, PS2_DATA, iPop,
        output oKey, oKeyValid, oCount, oFrameErr, oOverflow
    );

    modport master (
        output PS2_CLK, PS2_DATA, iPop,
        input  oKey, oKeyValid, oCount, oFrameErr, oOverflow
    );
endinterface

// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard receiver: oversampled deframer, make-code filter and a small scancode FIFO
// whose head feeds the KEY operand of the ALU.
module ps2_key_fifo #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic          Clock,
    input  logic          Reset,
    ps2_key_fifo_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          r_clk_s1, r_clk_s2, r_clk_s3;
    logic          r_dat_s1, r_dat_s2;
    logic          w_fall;

    state_t        r_state, w_state_next;
    logic [2:0]    r_bitcnt, w_bitcnt_next;
    logic [7:0]    r_shift, w_shift_next;
    logic          r_parity, w_parity_next;
    logic [TW-1:0] r_tcnt, w_tcnt_next;
    logic          r_break, w_break_next;
    logic          r_push, w_push_next;
    logic [7:0]    r_push_data;
    logic          r_frame_err, w_frame_err_next;
    logic          w_timeout;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rd_ptr, r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          w_full, w_empty, w_do_push, w_do_pop;

    // Sync flops reset to the idle-high line level so reset never fabricates a falling edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_clk_s3 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= bus.PS2_CLK;
            r_clk_s2 <= r_clk_s1;
            r_clk_s3 <= r_clk_s2;
            r_dat_s1 <= bus.PS2_DATA;
            r_dat_s2 <= r_dat_s1;
        end
    end

    assign w_fall    = r_clk_s3 & ~r_clk_s2;
    assign w_timeout = (r_state != IDLE) && !w_fall && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next     = r_state;
        w_bitcnt_next    = r_bitcnt;
        w_shift_next     = r_shift;
        w_parity_next    = r_parity;
        w_break_next     = r_break;
        w_push_next      = 1'b0;
        w_frame_err_next = 1'b0;
        w_tcnt_next      = '0;

        if (r_state != IDLE && !w_fall) begin
            w_tcnt_next = r_tcnt + TW'(1);
        end

        if (w_timeout) begin
            w_state_next     = IDLE;
            w_frame_err_next = 1'b1;
            w_tcnt_next      = '0;
        end else if (w_fall) begin
            unique case (r_state)
                IDLE: begin
                    if (!r_dat_s2) begin
                        w_state_next  = DATA;
                        w_bitcnt_next = 3'd0;
                    end
                end
                DATA: begin
                    w_shift_next  = {r_dat_s2, r_shift[7:1]};
                    w_bitcnt_next = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) w_state_next = PARITY;
                end
                PARITY: begin
                    w_parity_next = r_dat_s2;
                    w_state_next  = STOP;
                end
                STOP: begin
                    w_state_next = IDLE;
                    // Good frame: stop high and odd parity across data plus parity bit.
                    if (r_dat_s2 && (^{r_shift, r_parity})) begin
                        if (r_shift == 8'hF0) begin
                            w_break_next = 1'b1;
                        end else if (r_shift != 8'hE0) begin
                            if (r_break) w_break_next = 1'b0;
                            else         w_push_next  = 1'b1;
                        end
                    end else begin
                        w_frame_err_next = 1'b1;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_bitcnt    <= 3'd0;
            r_shift     <= 8'h00;
            r_parity    <= 1'b0;
            r_tcnt      <= '0;
            r_break     <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= 8'h00;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_bitcnt    <= w_bitcnt_next;
            r_shift     <= w_shift_next;
            r_parity    <= w_parity_next;
            r_tcnt      <= w_tcnt_next;
            r_break     <= w_break_next;
            r_push      <= w_push_next;
            r_frame_err <= w_frame_err_next;
            if (w_push_next) r_push_data <= r_shift;
        end
    end

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = bus.iPop & ~w_empty;
    assign w_do_push = r_push & (~w_full | w_do_pop);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (r_push && w_full && !bus.iPop) r_overflow <= 1'b1;
        end
    end

    // NOTE: storage is left unreset; r_count gates every read, so stale entries are never visible.
    always_ff @(posedge Clock) begin
        if (w_do_push) r_mem[r_wr_ptr] <= r_push_data;
    end

    assign bus.oKey      = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign bus.oKeyValid = ~w_empty;
    assign bus.oCount    = r_count;
    assign bus.oFrameErr = r_frame_err;
    assign bus.oOverflow = r_overflow;
endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed and randomized bench for ps2_key_fifo, checked against a queue-based scancode model.
module tb_ps2_key_fifo;
    localparam int DEPTH = 4;
    localparam int TMO   = 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_key_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    ps2_key_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int err_seen = 0;
    int exp_err  = 0;

    logic [7:0] q[$];
    bit m_break = 1'b0;
    bit m_ovf   = 1'b0;

    always @(negedge clk) if (!rst && bus.oFrameErr) err_seen++;

    initial begin
        #600000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [7:0] head;
        head = (q.size() != 0) ? q[0] : 8'h00;
        check({tag, "/count"}, 16'(bus.oCount), 16'(q.size()));
        check({tag, "/valid"}, 16'(bus.oKeyValid), 16'(q.size() != 0));
        check({tag, "/key"}, 16'(bus.oKey), 16'(head));
        check({tag, "/ovf"}, 16'(bus.oOverflow), 16'(m_ovf));
        check({tag, "/errs"}, 16'(err_seen), 16'(exp_err));
    endtask

    // Reference behaviour for one good byte: prefix filtering, then bounded enqueue.
    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) return;
        if (b == 8'hF0) begin m_break = 1'b1; return; end
        if (m_break) begin m_break = 1'b0; return; end
        if (q.size() < DEPTH) q.push_back(b);
        else m_ovf = 1'b1;
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk) bus.PS2_DATA = b;
        repeat (4) @(negedge clk);
        bus.PS2_CLK = 1'b0;
        repeat (8) @(negedge clk);
        bus.PS2_CLK = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // mode 0: plain; 1: also check the two-cycle enqueue latency; 2: pulse iPop in the push cycle.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int mode);
        logic [10:0] f;
        bit pre_valid;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 10; i++) ps2_bit(f[i]);
        @(negedge clk) bus.PS2_DATA = f[10];
        repeat (4) @(negedge clk);
        pre_valid = (q.size() != 0);
        bus.PS2_CLK = 1'b0;
        repeat (3) @(negedge clk);
        if (mode == 1) check("lat_pre/valid", 16'(bus.oKeyValid), 16'(pre_valid));
        if (mode == 2) bus.iPop = 1'b1;
        @(negedge clk);
        bus.iPop = 1'b0;
        if (mode == 2 && q.size() != 0) void'(q.pop_front());
        if (!bad_par && !bad_stop) model_byte(b);
        else exp_err++;
        if (mode == 1) check("lat_post/valid", 16'(bus.oKeyValid), 16'(q.size() != 0));
        repeat (4) @(negedge clk);
        bus.PS2_CLK = 1'b1;
        repeat (4) @(negedge clk);
        bus.PS2_DATA = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic do_pop();
        @(negedge clk) bus.iPop = 1'b1;
        @(negedge clk) bus.iPop = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        q.delete();
        m_break = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 1 && q.size() != 0; i++) begin
            check({tag, "/head"}, 16'(bus.oKey), 16'(q[0]));
            do_pop();
        end
        check_state({tag, "/empty"});
    endtask

    initial begin
        logic [7:0] rb;
        logic [7:0] part;
        bus.PS2_CLK  = 1'b1;
        bus.PS2_DATA = 1'b1;
        bus.iPop     = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        check_state("reset");

        send_frame(8'h1C, 1'b0, 1'b0, 1);
        check_state("single");
        do_pop();
        check_state("single_pop");

        send_frame(8'h1C, 1'b0, 1'b0, 0);
        send_frame(8'hF0, 1'b0, 1'b0, 0);
        send_frame(8'h1C, 1'b0, 1'b0, 0);
        send_frame(8'hE0, 1'b0, 1'b0, 0);
        send_frame(8'h75, 1'b0, 1'b0, 0);
        check_state("filter");
        drain("filter");

        send_frame(8'h1C, 1'b1, 1'b0, 0);
        check_state("bad_parity");
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        check_state("bad_stop");
        send_frame(8'h32, 1'b0, 1'b0, 0);
        check_state("after_err");
        drain("after_err");

        send_frame(8'h15, 1'b0, 1'b0, 0);
        send_frame(8'h1D, 1'b0, 1'b0, 0);
        send_frame(8'h24, 1'b0, 1'b0, 0);
        send_frame(8'h2D, 1'b0, 1'b0, 0);
        send_frame(8'h2C, 1'b0, 1'b0, 0);
        check_state("overflow");
        drain("overflow");

        do_reset();
        check_state("reset2");
        send_frame(8'h16, 1'b0, 1'b0, 0);
        send_frame(8'h1E, 1'b0, 1'b0, 0);
        send_frame(8'h26, 1'b0, 1'b0, 0);
        send_frame(8'h25, 1'b0, 1'b0, 0);
        send_frame(8'h2E, 1'b0, 1'b0, 2);
        check_state("full_pop_push");
        drain("full_pop_push");

        part = 8'h1C;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(part[i]);
        repeat (TMO + 20) @(negedge clk);
        exp_err++;
        check_state("timeout");
        send_frame(8'h1C, 1'b0, 1'b0, 0);
        check_state("after_timeout");

        send_frame(8'h33, 1'b0, 1'b0, 0);
        part = 8'h4B;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(part[i]);
        @(negedge clk) bus.PS2_DATA = part[4];
        repeat (2) @(negedge clk);
        do_reset();
        check_state("mid_reset");
        bus.PS2_DATA = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h1C, 1'b0, 1'b0, 0);
        check_state("after_reset");

        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 9))
                0:       rb = 8'hF0;
                1:       rb = 8'hE0;
                default: rb = 8'($urandom);
            endcase
            send_frame(rb, ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0),
                       ($urandom_range(0, 3) == 0) ? 2 : 0);
            if ($urandom_range(0, 2) == 0) do_pop();
            check_state("random");
        end
        drain("final");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
